// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift-right/shift-left/load register with serial word-completion tracking
`timescale 1ns/1ps
module univ_shift_reg #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SIR,
  input  logic             SIL,
  input  logic [WIDTH-1:0] PIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    BIT_CNT,
  output logic             WORD_VALID
);
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_wv;
  logic [WIDTH-1:0] w_next;
  logic             w_shift;
  logic             w_last;
  always_comb begin
    w_next  = MODE == 2'b01 ? {SIR, r_q[WIDTH-1:1]} :
              MODE == 2'b10 ? {r_q[WIDTH-2:0], SIL} :
              MODE == 2'b11 ? PIN : r_q;
    w_shift = EN && (MODE == 2'b01 || MODE == 2'b10);
    w_last  = r_cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q   <= '0;
      r_cnt <= '0;
      r_wv  <= 1'b0;
    end else begin
      r_wv <= w_shift && w_last;
      if (EN) r_q <= w_next;
      if (w_shift) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      else if (EN && MODE == 2'b11) r_cnt <= '0;
    end
  end
  assign Q          = r_q;
  assign SOR        = r_q[0];
  assign SOL        = r_q[WIDTH-1];
  assign BIT_CNT    = r_cnt;
  assign WORD_VALID = r_wv;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors plus an arithmetic reference model checked every cycle
`timescale 1ns/1ps
module tb_univ_shift_reg;
  localparam int W = 4;
  logic         CLK, CLR, EN, SIR, SIL;
  logic [1:0]   MODE;
  logic [W-1:0] PIN, Q;
  logic         SOR, SOL, WORD_VALID;
  logic [1:0]   BIT_CNT;
  int total = 0, bad = 0;
  int m_q = 0, m_cnt = 0, m_wv = 0;
  univ_shift_reg #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .SIR(SIR), .SIL(SIL), .PIN(PIN),
    .Q(Q), .SOR(SOR), .SOL(SOL), .BIT_CNT(BIT_CNT), .WORD_VALID(WORD_VALID)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: register value as an integer, word progress as a count modulo W.
  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m_q = 0; m_cnt = 0; m_wv = 0;
    end else begin
      m_wv = 0;
      if (EN) begin
        if (MODE == 2'b11) begin
          m_q = int'(PIN); m_cnt = 0;
        end else if (MODE != 2'b00) begin
          m_q = MODE == 2'b01 ? (m_q >> 1) + (int'(SIR) << (W - 1))
                              : ((m_q << 1) + int'(SIL)) % (1 << W);
          m_cnt = (m_cnt + 1) % W;
          m_wv = m_cnt == 0 ? 1 : 0;
        end
      end
    end
  end
  always @(negedge CLK) begin
    chk("m_q", Q, m_q);
    chk("m_sor", SOR, m_q % 2);
    chk("m_sol", SOL, (m_q >> (W - 1)) % 2);
    chk("m_cnt", BIT_CNT, m_cnt);
    chk("m_wv", WORD_VALID, m_wv);
  end
  task automatic step(input logic en, input logic [1:0] md, input logic sir, input logic sil,
                      input logic [W-1:0] pin);
    EN = en; MODE = md; SIR = sir; SIL = sil; PIN = pin;
    @(posedge CLK);
    #1;
  endtask
  logic [W-1:0] exp_r [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
  logic [W-1:0] exp_l [4] = '{4'b0111, 4'b1111, 4'b1110, 4'b1100};
  logic         sir_v [4] = '{1, 0, 1, 1};
  logic         sil_v [4] = '{1, 1, 0, 0};
  logic         sol_v [4] = '{1, 0, 1, 1};
  initial begin
    CLR = 1; EN = 0; MODE = 0; SIR = 0; SIL = 0; PIN = 0;
    repeat (2) @(posedge CLK);
    #1 CLR = 0;
    chk("rst_q", Q, 0);
    chk("rst_cnt", BIT_CNT, 0);
    // async reset mid-cycle
    step(1, 2'b11, 0, 0, 4'b1011);
    chk("ar_load", Q, 4'b1011);
    #2 CLR = 1;
    #1;
    chk("ar_q", Q, 0);
    chk("ar_cnt", BIT_CNT, 0);
    chk("ar_wv", WORD_VALID, 0);
    step(1, 2'b11, 0, 0, 4'b1111);
    step(1, 2'b01, 1, 0, 4'b1111);
    chk("ar_frozen", Q, 0);
    CLR = 0;
    // load / hold
    step(1, 2'b11, 0, 0, 4'b1011);
    chk("ld_q", Q, 4'b1011);
    chk("ld_cnt", BIT_CNT, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 1, 1, 4'b0000);
      chk("hold_q", Q, 4'b1011);
      chk("hold_wv", WORD_VALID, 0);
    end
    // shift right
    step(1, 2'b11, 0, 0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, sir_v[i], 0, 4'b0000);
      chk("sr_q", Q, exp_r[i]);
      chk("sr_sor", SOR, exp_r[i][0]);
      chk("sr_wv", WORD_VALID, i == 3);
    end
    chk("sr_cnt", BIT_CNT, 0);
    step(1, 2'b00, 0, 0, 4'b0000);
    chk("sr_wv_drop", WORD_VALID, 0);
    // shift left
    step(1, 2'b11, 0, 0, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      chk("sl_sol_pre", SOL, sol_v[i]);
      step(1, 2'b10, 0, sil_v[i], 4'b0000);
      chk("sl_q", Q, exp_l[i]);
      chk("sl_wv", WORD_VALID, i == 3);
    end
    // enable gating
    step(1, 2'b11, 0, 0, 4'b0000);
    step(1, 2'b01, 1, 0, 4'b0000);
    step(1, 2'b01, 1, 0, 4'b0000);
    chk("en_cnt2", BIT_CNT, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b01, 1, 1, 4'b1111);
      chk("en_q", Q, 4'b1100);
      chk("en_cnt", BIT_CNT, 2);
      chk("en_wv", WORD_VALID, 0);
    end
    step(1, 2'b01, 0, 0, 4'b0000);
    chk("en_q3", Q, 4'b0110);
    chk("en_wv3", WORD_VALID, 0);
    step(1, 2'b01, 0, 0, 4'b0000);
    chk("en_q4", Q, 4'b0011);
    chk("en_wv4", WORD_VALID, 1);
    // load abandons partial word
    step(1, 2'b11, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 4'b0000);
    chk("lm_cnt3", BIT_CNT, 3);
    chk("lm_q3", Q, 4'b1110);
    step(1, 2'b11, 0, 0, 4'b0110);
    chk("lm_q", Q, 4'b0110);
    chk("lm_cnt", BIT_CNT, 0);
    chk("lm_wv", WORD_VALID, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, i % 2 ? 2'b01 : 2'b10, 0, 0, 4'b0000);
      chk("lm_wv_n", WORD_VALID, i == 3);
    end
    // mixed traffic against the model
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parameterised universal shift register assembled from edge-triggered D storage, with hold, shift-right, shift-left and parallel-load modes.
- Tracks serial word assembly: pulses WORD_VALID when WIDTH bits have been shifted in since the last clear or load.
- Sits directly downstream of the lab's single-bit D flip-flop stage: it consumes serial data bits and converts between serial and parallel form for later stages.

Parameters:
- WIDTH, 4, register width in bits; must be >= 2.
- CW, $clog2(WIDTH), width of BIT_CNT; derived, not overridden.

Ports:
- CLK  input  1  clock; rising-edge active.
- CLR  input  1  asynchronous, active-high reset.
- EN  input  1  clock enable; 0 freezes Q and BIT_CNT.
- MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- SIR  input  1  serial input entering at the MSB on shift right.
- SIL  input  1  serial input entering at the LSB on shift left.
- PIN  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- SOR  output  1  serial output for shift right; equals Q[0].
- SOL  output  1  serial output for shift left; equals Q[WIDTH-1].
- BIT_CNT  output  CW  number of shifts completed in the current word.
- WORD_VALID  output  1  one-cycle pulse marking a completed WIDTH-bit word.

Behaviour:
- Reset: CLR=1 forces Q=0, BIT_CNT=0 and WORD_VALID=0 immediately, without waiting for a clock edge, and holds them while CLR is high. CLR overrides EN, MODE and every other input.
- After CLR deasserts, the first state update happens at the next rising CLK.
- All state updates on the rising CLK edge. SOR and SOL are combinational from Q.
- EN=0: Q and BIT_CNT hold; WORD_VALID is 0 on the next edge.
- EN=1, per MODE:
  - MODE=00 (hold): Q holds; BIT_CNT holds; WORD_VALID<=0.
  - MODE=01 (shift right): Q<={SIR,Q[WIDTH-1:1]}.
  - MODE=10 (shift left): Q<={Q[WIDTH-2:0],SIL}.
  - MODE=11 (load): Q<=PIN; BIT_CNT<=0; WORD_VALID<=0. A load abandons any partial word.
- Shift counting, for either shift direction with EN=1:
  - BIT_CNT==WIDTH-1: BIT_CNT wraps to 0 and WORD_VALID<=1.
  - Otherwise: BIT_CNT<=BIT_CNT+1 and WORD_VALID<=0.
- WORD_VALID is registered, high for exactly one cycle, coincident with Q holding the completed word. Back-to-back words give WORD_VALID high every WIDTH shifting cycles.
- Changing shift direction mid-word does not reset BIT_CNT; shifts in both directions count toward the same word.
- Latency: one cycle from edge to Q for every mode. No combinational path from SIR, SIL or PIN to any output.
- CLR asserted mid-word: partial word discarded; BIT_CNT restarts at 0 after release.

Test Plan (WIDTH=4):
- Async reset: load Q=1011, then raise CLR 3 ns after a rising edge -> Q=0000, BIT_CNT=0, WORD_VALID=0 before the next edge; state stays frozen while CLR=1.
- Load/hold: MODE=11, PIN=1011, one edge -> Q=1011, BIT_CNT=0; then MODE=00 for 3 edges -> Q stays 1011, WORD_VALID=0.
- Shift right from 0000: SIR=1,0,1,1 on 4 edges -> Q=1000, 0100, 1010, 1101; SOR=0,0,0,1; WORD_VALID=1 only in the cycle after the 4th edge; BIT_CNT=0.
- Shift left from a load of 1011: SIL=1,1,0,0 -> Q=0111, 1111, 1110, 1100; SOL before each edge = 1,0,1,1; WORD_VALID pulses once after the 4th shift.
- Enable gating: 2 right shifts, then EN=0 for 3 edges (Q and BIT_CNT=2 hold), then 2 more shifts -> WORD_VALID pulses only after the 4th actual shift.
- Load mid-word: 3 shifts (BIT_CNT=3), then MODE=11 with PIN=0110 -> Q=0110, BIT_CNT=0, no WORD_VALID; the next full word needs 4 more shifts.
